// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit timing and receive FSM states.
// Used by the receive deserializer and, later, the transmit side.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for asynchronous single-bit inputs.
// Resets to 1 so that an idle-high line does not look like activity.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer with a single-entry valid/ready output buffer,
// framing-error and overrun pulses, and break (held-low line) handling.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_e state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic [2:0]                bit_idx, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic                      byte_done;
    logic                      stop_bad;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (uart_rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // The counter restarts on entry to START, so the first sample lands H
    // cycles after T0 and every later sample a full bit period after that.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_done    = 1'b0;
        stop_bad     = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift[UART_DATA_BITS-1:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && rx_valid && !rx_ready;
            busy      <= (state_next != IDLE);
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser at CLKS_PER_BIT=8, SYNC_STAGES=2.
module tb_uart_rx_deser;

    localparam int N = 8;
    localparam int H = N / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] beats[$];
    int fe_cnt, ov_cnt;
    int valid_rise_cyc, valid_run, last_valid_run;
    int low_run, high_run, min_low_run, max_high_run;
    int last_start;
    logic valid_d = 1'b0;
    logic busy_d = 1'b0;

    uart_rx_deser #(
        .CLKS_PER_BIT(N),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) beats.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && !valid_d) valid_rise_cyc = cyc;
        if (rx_valid) begin
            valid_run++;
        end else begin
            if (valid_d) last_valid_run = valid_run;
            valid_run = 0;
        end
        if (busy) begin
            if (!busy_d && low_run < min_low_run) min_low_run = low_run;
            low_run = 0;
            high_run++;
            if (high_run > max_high_run) max_high_run = high_run;
        end else begin
            high_run = 0;
            low_run++;
        end
        valid_d = rx_valid;
        busy_d  = busy;
    end

    task automatic clear_stats();
        beats.delete();
        fe_cnt         = 0;
        ov_cnt         = 0;
        valid_rise_cyc = -1;
        last_valid_run = 0;
        min_low_run    = 1000000;
        max_high_run   = 0;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [7:0] d;
        d = b;
        last_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        idle(4);
    endtask

    task automatic test_basic();
        clear_stats();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(10);
        checks++; if (beats.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d beats expected 1", beats.size()); end
        if (beats.size() >= 1) begin
            checks++; if (beats[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", beats[0]); end
        end
        checks++; if (valid_rise_cyc - last_start !== 79) begin errors++; $display("FAIL basic_latency: got %0d expected 79", valid_rise_cyc - last_start); end
        checks++; if (last_valid_run !== 1) begin errors++; $display("FAIL basic_valid_width: got %0d expected 1", last_valid_run); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL basic_no_errors: got %0d pulses expected 0", fe_cnt + ov_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(10);
        checks++; if (beats.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d beats expected 2", beats.size()); end
        if (beats.size() >= 2) begin
            checks++; if (beats[0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", beats[0]); end
            checks++; if (beats[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", beats[1]); end
        end
        // IDLE spans from the cycle after the stop sample to the next T0: N-H cycles.
        checks++; if (min_low_run !== N - H) begin errors++; $display("FAIL b2b_busy_gap: got %0d expected %0d", min_low_run, N - H); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL b2b_no_errors: got %0d pulses expected 0", fe_cnt + ov_cnt); end
    endtask

    task automatic test_overrun();
        clear_stats();
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(10);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ovr_data_held: got %h expected 3c", rx_data); end
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL ovr_no_beat: got %0d beats expected 0", beats.size()); end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b expected 0", rx_valid); end
        checks++; if (beats.size() !== 1) begin errors++; $display("FAIL ovr_drain_count: got %0d beats expected 1", beats.size()); end
        if (beats.size() >= 1) begin
            checks++; if (beats[0] !== 8'h3C) begin errors++; $display("FAIL ovr_drain_data: got %h expected 3c", beats[0]); end
        end
        idle(4);
    endtask

    task automatic test_glitch();
        clear_stats();
        rx_ready = 1'b1;
        uart_rx  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(3 * N);
        checks++; if (beats.size() + fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL glitch_no_events: got %0d events expected 0", beats.size() + fe_cnt + ov_cnt); end
        checks++; if (max_high_run < 1 || max_high_run > H) begin errors++; $display("FAIL glitch_busy_len: got %0d expected 1..%0d", max_high_run, H); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        clear_stats();
        rx_ready = 1'b1;
        d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        uart_rx = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL fe_pulses: got %0d expected 1", fe_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fe_in_break: busy got %b expected 1", busy); end
        checks++; if (beats.size() !== 0) begin errors++; $display("FAIL fe_no_beat: got %0d beats expected 0", beats.size()); end
        @(posedge clk); #1;
        idle(2 * N);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_break_exit: busy got %b expected 0", busy); end
        send_frame(8'h12, 1'b1);
        idle(10);
        checks++; if (beats.size() !== 1) begin errors++; $display("FAIL fe_recover_count: got %0d beats expected 1", beats.size()); end
        if (beats.size() >= 1) begin
            checks++; if (beats[0] !== 8'h12) begin errors++; $display("FAIL fe_recover_data: got %h expected 12", beats[0]); end
        end
        checks++; if (fe_cnt !== 1 || ov_cnt !== 0) begin errors++; $display("FAIL fe_recover_errs: got fe=%0d ov=%0d expected fe=1 ov=0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        clear_stats();
        rx_ready = 1'b1;
        d = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        uart_rx = d[4];
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        uart_rx = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", rx_valid); end
        @(posedge clk); #1;
        idle(12 * N);
        checks++; if (beats.size() + fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL mid_reset_quiet: got %0d events expected 0", beats.size() + fe_cnt + ov_cnt); end
        send_frame(8'h7E, 1'b1);
        idle(10);
        checks++; if (beats.size() !== 1) begin errors++; $display("FAIL mid_reset_next_count: got %0d beats expected 1", beats.size()); end
        if (beats.size() >= 1) begin
            checks++; if (beats[0] !== 8'h7E) begin errors++; $display("FAIL mid_reset_next_data: got %h expected 7e", beats[0]); end
        end
    endtask

    initial begin
        low_run  = 0;
        high_run = 0;
        clear_stats();
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
